// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one uP memory bus among NUM_REQ requesters.
// Requester 0 (JTAG) has fixed priority; the others rotate round-robin.
module mem_bus_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int NUM_REQ     = 2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [NUM_REQ-1:0]        i_reqValid,
  input  logic [NUM_REQ-1:0]        i_reqWr,
  input  logic [NUM_REQ*ADDR_W-1:0] i_reqAddr,
  input  logic [NUM_REQ*DATA_W-1:0] i_reqData,
  output logic [NUM_REQ-1:0]        o_reqGrant,
  output logic [NUM_REQ-1:0]        o_reqDone,
  output logic [DATA_W-1:0]         o_rdData,
  output logic [ADDR_W-1:0]         o_memAddr,
  output logic                      o_memWr,
  output logic                      o_memEn,
  inout  logic [DATA_W-1:0]         io_memData
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RR_N  = (NUM_REQ > 1) ? NUM_REQ - 1 : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] PTR_RST =
    (NUM_REQ > 1) ? IDX_W'(1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    TURN
  } state_t;

  state_t state, stateNext;

  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  ptrNext;
  logic [IDX_W-1:0]  winIdx;
  logic              winValid;
  logic [IDX_W-1:0]  curIdx;
  logic              curWr;
  logic [DATA_W-1:0] wrData;
  logic [CNT_W-1:0]  cnt;
  logic              lastCycle;

  assign lastCycle = (cnt == '0);

  // Only a write access drives the shared data lines.
  assign io_memData = (state == ACCESS && curWr) ?
                      wrData : {DATA_W{1'bz}};

  // Pick a winner: JTAG first, else first valid at/after the pointer.
  always_comb begin
    int cand;
    cand     = 0;
    winValid = 1'b0;
    winIdx   = '0;
    if (i_reqValid[0]) begin
      winValid = 1'b1;
    end else begin
      for (int i = RR_N - 1; i >= 0; i--) begin
        cand = ((int'(ptr) - 1 + i) % RR_N) + 1;
        if (cand < NUM_REQ && i_reqValid[IDX_W'(cand)]) begin
          winValid = 1'b1;
          winIdx   = IDX_W'(cand);
        end
      end
    end
  end

  // Pointer moves past a round-robin winner; JTAG grants leave it alone.
  always_comb begin
    int nxt;
    nxt     = 0;
    ptrNext = ptr;
    if (winIdx != '0) begin
      nxt = int'(winIdx) + 1;
      if (nxt >= NUM_REQ) nxt = 1;
      ptrNext = IDX_W'(nxt);
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= stateNext;
  end

  // Next-state: arbitrate in IDLE, count out ACCESS, one TURN cycle.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (winValid) stateNext = ACCESS;
      ACCESS:  if (lastCycle) stateNext = TURN;
      TURN:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Bus outputs, transaction latches and handshake pulses.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ptr        <= PTR_RST;
      cnt        <= '0;
      curIdx     <= '0;
      curWr      <= 1'b0;
      wrData     <= '0;
      o_memAddr  <= '0;
      o_memWr    <= 1'b0;
      o_memEn    <= 1'b0;
      o_reqGrant <= '0;
      o_reqDone  <= '0;
      o_rdData   <= '0;
    end else begin
      o_reqGrant <= '0;
      o_reqDone  <= '0;
      unique case (state)
        IDLE: begin
          if (winValid) begin
            curIdx     <= winIdx;
            curWr      <= i_reqWr[winIdx];
            wrData     <= i_reqData[int'(winIdx)*DATA_W +: DATA_W];
            o_memAddr  <= i_reqAddr[int'(winIdx)*ADDR_W +: ADDR_W];
            o_memWr    <= i_reqWr[winIdx];
            o_memEn    <= 1'b1;
            o_reqGrant <= NUM_REQ'(1) << winIdx;
            cnt        <= CNT_W'(WAIT_CYCLES - 1);
            ptr        <= ptrNext;
          end
        end
        ACCESS: begin
          if (lastCycle) begin
            o_memEn   <= 1'b0;
            o_memWr   <= 1'b0;
            o_reqDone <= NUM_REQ'(1) << curIdx;
            if (!curWr) o_rdData <= io_memData;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed table, corner sequences and a
// randomized run against a transaction-level timeline model.
module tb_mem_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int NR = 4;
  localparam int W  = 3;

  logic              clk;
  logic              rstn;
  logic [NR-1:0]     reqValid;
  logic [NR-1:0]     reqWr;
  logic [NR*AW-1:0]  reqAddr;
  logic [NR*DW-1:0]  reqData;
  logic [NR-1:0]     reqGrant;
  logic [NR-1:0]     reqDone;
  logic [DW-1:0]     rdData;
  logic [AW-1:0]     memAddr;
  logic              memWr;
  logic              memEn;
  wire  [DW-1:0]     memData;

  int nVec = 0;
  int nErr = 0;

  mem_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_REQ(NR), .WAIT_CYCLES(W)
  ) dut (
    .i_clk(clk),
    .i_rstn(rstn),
    .i_reqValid(reqValid),
    .i_reqWr(reqWr),
    .i_reqAddr(reqAddr),
    .i_reqData(reqData),
    .o_reqGrant(reqGrant),
    .o_reqDone(reqDone),
    .o_rdData(rdData),
    .o_memAddr(memAddr),
    .o_memWr(memWr),
    .o_memEn(memEn),
    .io_memData(memData)
  );

  function automatic logic [DW-1:0] memFn(logic [AW-1:0] a);
    return (a == 16'h0100) ? 16'h1234 : (a ^ 16'hA5A5);
  endfunction

  // Memory answers reads while enabled.
  assign memData = (memEn && !memWr) ? memFn(memAddr) : 'z;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic setReq(input int k, input bit v, input bit wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    reqValid[k]        = v;
    reqWr[k]           = wr;
    reqAddr[k*AW +: AW] = a;
    reqData[k*DW +: DW] = d;
  endtask

  typedef struct {
    int          idx;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] expRd;
  } vec_t;

  // Single request from idle; checks full access timeline.
  task automatic runVec(input vec_t v);
    setReq(v.idx, 1'b1, v.wr, v.addr, v.data);
    for (int c = 1; c <= W + 2; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("grant", reqGrant, 64'(1) << v.idx);
        setReq(v.idx, 1'b0, v.wr, v.addr, v.data);
      end else begin
        chk("grantIdle", reqGrant, 0);
      end
      chk("memEn", memEn, c <= W);
      chk("memWr", memWr, (c <= W) && v.wr);
      chk("memAddr", memAddr, v.addr);
      if (c <= W && v.wr) chk("busData", memData, v.data);
      chk("done", reqDone, (c == W + 1) ? (64'(1) << v.idx) : 0);
      if (c == W + 1) chk("rdData", rdData, v.expRd);
    end
  endtask

  // Wait (bounded) for the next grant; gap counts negedges waited.
  task automatic nextGrant(output logic [NR-1:0] g, output int gap);
    g   = '0;
    gap = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (reqGrant != '0) begin
        g   = reqGrant;
        gap = i;
        break;
      end
    end
    if (gap < 0) begin
      nVec++;
      nErr++;
      $display("FAIL grantTimeout: got none expected a grant");
    end
  endtask

  // Random-phase requesters and model.
  bit   [NR-1:0] pend;
  bit            pWr   [NR];
  logic [AW-1:0] pAddr [NR];
  logic [DW-1:0] pData [NR];
  int            mAge, mIdx, mPtr;
  bit            mWr;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mData;
  logic [NR-1:0] eGrant, eDone;
  bit            eEn, eWr;
  logic [DW-1:0] eRd;

  task automatic randStep();
    int win;
    int k;
    chk("rGrant", reqGrant, eGrant);
    chk("rDone", reqDone, eDone);
    chk("rEn", memEn, eEn);
    chk("rWr", memWr, eWr);
    chk("rAddr", memAddr, mAddr);
    chk("rRd", rdData, eRd);
    if (eEn && mWr) chk("rBus", memData, mData);
    if (mAge == 1) pend[mIdx] = 1'b0;
    for (int r = 0; r < NR; r++) begin
      if (!pend[r]) begin
        if ($urandom_range((r == 0) ? 11 : 3, 0) == 0) begin
          pend[r]  = 1'b1;
          pWr[r]   = 1'($urandom_range(1, 0));
          pAddr[r] = 16'($urandom);
          pData[r] = 16'($urandom);
        end
      end else if ($urandom_range(19, 0) == 0) begin
        pend[r] = 1'b0;
      end
      setReq(r, pend[r], pWr[r], pAddr[r], pData[r]);
    end
    if (mAge == 0) begin
      win = -1;
      if (pend[0]) win = 0;
      else begin
        for (int off = 0; off < NR - 1; off++) begin
          k = ((mPtr - 1 + off) % (NR - 1)) + 1;
          if (win < 0 && pend[k]) win = k;
        end
      end
      if (win >= 0) begin
        mAge  = 1;
        mIdx  = win;
        mWr   = pWr[win];
        mAddr = pAddr[win];
        mData = pData[win];
        if (win > 0) mPtr = (win == NR - 1) ? 1 : win + 1;
      end
    end else if (mAge == W + 1) begin
      mAge = 0;
    end else begin
      mAge++;
    end
    eGrant = (mAge == 1) ? NR'(1) << mIdx : '0;
    eDone  = (mAge == W + 1) ? NR'(1) << mIdx : '0;
    eEn    = (mAge >= 1 && mAge <= W);
    eWr    = eEn && mWr;
    if (mAge == W + 1 && !mWr) eRd = memFn(mAddr);
  endtask

  vec_t          tbl [5];
  logic [NR-1:0] g;
  int            gap;
  int            rrExp [4];

  initial begin
    tbl[0] = '{0, 1'b1, 16'h0040, 16'hBEEF, 16'h0000};
    tbl[1] = '{1, 1'b0, 16'h0100, 16'h0000, 16'h1234};
    tbl[2] = '{2, 1'b1, 16'h0200, 16'h5555, 16'h1234};
    tbl[3] = '{3, 1'b0, 16'h0300, 16'h0000, 16'hA6A5};
    tbl[4] = '{0, 1'b0, 16'h0100, 16'h0000, 16'h1234};
    rrExp  = '{1, 2, 3, 1};

    rstn = 1'b0;
    reqValid = '0;
    reqWr = '0;
    reqAddr = '0;
    reqData = '0;
    @(negedge clk);
    chk("rstGrant", reqGrant, 0);
    chk("rstDone", reqDone, 0);
    chk("rstEn", memEn, 0);
    chk("rstWr", memWr, 0);
    chk("rstAddr", memAddr, 0);
    chk("rstRd", rdData, 0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) runVec(tbl[i]);

    // Round-robin with 1,2,3 held continuously.
    for (int k = 1; k < NR; k++) setReq(k, 1'b1, 1'b0, 16'(16'h1000 + k), 0);
    for (int i = 0; i < 4; i++) begin
      nextGrant(g, gap);
      chk("rrGrant", g, 64'(1) << rrExp[i]);
      chk("rrGap", gap, (i == 0) ? 1 : W + 2);
    end
    for (int k = 1; k < NR; k++) setReq(k, 1'b0, 1'b0, 0, 0);
    repeat (W + 1) @(negedge clk);

    // Pointer at 2: JTAG first, then 2 (pointer untouched), then 1.
    setReq(0, 1'b1, 1'b1, 16'h0A00, 16'h1111);
    setReq(1, 1'b1, 1'b1, 16'h0A01, 16'h2222);
    setReq(2, 1'b1, 1'b1, 16'h0A02, 16'h3333);
    nextGrant(g, gap);
    chk("prioGrant0", g, 4'b0001);
    chk("prioGap0", gap, 1);
    setReq(0, 1'b0, 1'b1, 0, 0);
    nextGrant(g, gap);
    chk("prioGrant2", g, 4'b0100);
    chk("prioGap2", gap, W + 2);
    setReq(2, 1'b0, 1'b1, 0, 0);
    nextGrant(g, gap);
    chk("prioGrant1", g, 4'b0010);
    chk("prioGap1", gap, W + 2);
    setReq(1, 1'b0, 1'b1, 0, 0);
    repeat (W + 1) @(negedge clk);

    // Reset in the middle of a write access.
    setReq(2, 1'b1, 1'b1, 16'h0777, 16'hCAFE);
    @(negedge clk);
    chk("midGrant", reqGrant, 4'b0100);
    setReq(2, 1'b0, 1'b1, 0, 0);
    @(negedge clk);
    chk("midEn", memEn, 1);
    chk("midBus", memData, 16'hCAFE);
    #2 rstn = 1'b0;
    #1;
    chk("arstEn", memEn, 0);
    chk("arstWr", memWr, 0);
    chk("arstAddr", memAddr, 0);
    chk("arstRd", rdData, 0);
    @(negedge clk);
    chk("arstDone", reqDone, 0);
    rstn = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      chk("postDone", reqDone, 0);
      chk("postEn", memEn, 0);
    end
    setReq(1, 1'b1, 1'b0, 16'h0B01, 0);
    setReq(3, 1'b1, 1'b0, 16'h0B03, 0);
    nextGrant(g, gap);
    chk("ptrRstGrant1", g, 4'b0010);
    setReq(1, 1'b0, 1'b0, 0, 0);
    nextGrant(g, gap);
    chk("ptrRstGrant3", g, 4'b1000);
    chk("ptrRstGap3", gap, W + 2);
    setReq(3, 1'b0, 1'b0, 0, 0);
    repeat (W + 1) @(negedge clk);
    runVec('{0, 1'b0, 16'h0100, 16'h0000, 16'h1234});

    // Randomized run from a fresh reset.
    rstn = 1'b0;
    pend = '0;
    for (int k = 0; k < NR; k++) begin
      pWr[k] = 1'b0;
      pAddr[k] = '0;
      pData[k] = '0;
      setReq(k, 1'b0, 1'b0, 0, 0);
    end
    mAge = 0; mIdx = 0; mPtr = 1; mWr = 1'b0;
    mAddr = '0; mData = '0;
    eGrant = '0; eDone = '0; eEn = 1'b0; eWr = 1'b0; eRd = '0;
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      randStep();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
